// File: rtl/decode_queue.sv
// Pre-decoding instruction FIFO between fetch and issue, with single-cycle flush.
// Optional DECODE_QUEUE_PERF_EN adds saturating stall and illegal-push counters.
module decode_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [PC_WIDTH-1:0]      in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [3:0]               out_opclass,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic                     out_regwrite,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
`ifdef DECODE_QUEUE_PERF_EN
    ,
    output logic [31:0]              perf_stall,
    output logic [31:0]              perf_illegal
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    logic [31:0]         inst_mem    [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem      [DEPTH];
    logic [3:0]          class_mem   [DEPTH];
    logic                rw_mem      [DEPTH];
    logic                illegal_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic       push;
    logic       pop;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] dec_class;
    logic       dec_rw;
    logic       dec_illegal;

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    always_comb begin
        logic [3:0] cls;
        logic       bad;
        logic       rw;
        cls = CLS_ILLEGAL;
        bad = 1'b0;
        rw  = 1'b0;
        case (opcode)
            OPC_OP: begin
                cls = 4'd0;
                rw  = 1'b1;
                bad = !(funct7 == 7'b0000000 || funct7 == 7'b0100000) ||
                      (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101);
            end
            OPC_OP_IMM: begin
                cls = 4'd1;
                rw  = 1'b1;
                bad = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
                      (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000);
            end
            OPC_LOAD: begin
                cls = 4'd2;
                rw  = 1'b1;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                cls = 4'd3;
                bad = (funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                cls = 4'd4;
                bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_JAL: begin
                cls = 4'd5;
                rw  = 1'b1;
            end
            OPC_JALR: begin
                cls = 4'd6;
                rw  = 1'b1;
                bad = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                cls = 4'd7;
                rw  = 1'b1;
            end
            OPC_AUIPC: begin
                cls = 4'd8;
                rw  = 1'b1;
            end
            OPC_SYSTEM: begin
                cls = 4'd9;
                rw  = (funct3 != 3'b000);
            end
            OPC_MISC_MEM: begin
                cls = 4'd10;
                bad = (funct3 > 3'b001);
            end
            default: bad = 1'b1;
        endcase
        dec_illegal = bad;
        dec_class   = bad ? CLS_ILLEGAL : cls;
        dec_rw      = bad ? 1'b0 : rw;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage carries no reset; entries are only observed once count covers them.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            inst_mem[wr_ptr]    <= in_inst;
            pc_mem[wr_ptr]      <= in_pc;
            class_mem[wr_ptr]   <= dec_class;
            rw_mem[wr_ptr]      <= dec_rw;
            illegal_mem[wr_ptr] <= dec_illegal;
        end
    end

    assign out_inst     = out_valid ? inst_mem[rd_ptr] : '0;
    assign out_pc       = out_valid ? pc_mem[rd_ptr] : '0;
    assign out_opclass  = out_valid ? class_mem[rd_ptr] : '0;
    assign out_regwrite = out_valid ? rw_mem[rd_ptr] : 1'b0;
    assign out_illegal  = out_valid ? illegal_mem[rd_ptr] : 1'b0;
    assign out_rd       = out_inst[11:7];
    assign out_rs1      = out_inst[19:15];
    assign out_rs2      = out_inst[24:20];

`ifdef DECODE_QUEUE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall   <= '0;
            perf_illegal <= '0;
        end else begin
            if (in_valid && !in_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
            // A push discarded by a same-cycle flush is not counted.
            if (push && !flush && dec_illegal && perf_illegal != '1)
                perf_illegal <= perf_illegal + 32'd1;
        end
    end
`endif

endmodule
